lut_readback: RTL and testbench

Sequential readback engine for the 16-entry, 1-bit-wide truth-table RAM filled by the LUT evaluation block. On a start pulse it snapshots the RAM contents, then streams each entry out in address order, 0 to DEPTH-1, over a valid/ready handshake. It keeps a running count of set entries and signals completion. It sits between the LUT RAM and any downstream checker or serializer, and is the read side of the LUT write path.

---
 rtl/lut_readback_if.sv | 12 +
 rtl/lut_readback.sv | 80 ++++++++
 tb/tb_lut_readback.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_readback_if.sv
// Valid/ready beat stream carrying one truth-table entry (address + bit) per beat.
interface lut_readback_if #(
  parameter int AW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_bit;

  modport master (output out_valid, output out_addr, output out_bit, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_bit, output out_ready);
endinterface

// File: rtl/lut_readback.sv
// Snapshots the LUT RAM on start and streams entries 0..DEPTH-1 over a
// valid/ready interface, counting set entries and pulsing done at the end.
module lut_readback #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DEPTH-1:0]   ram,
  input  logic               start,
  input  logic               abort,
  lut_readback_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        ones_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] snap_q, snap_d;
  logic [AW:0]      ones_q, ones_d;
  logic             cur_bit;

  assign cur_bit = snap_q[cnt_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = ram;
          cnt_d   = '0;
          ones_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // abort wins over a beat presented in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          ones_d = ones_q + (AW+1)'(cur_bit);
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_addr  = cnt_q;
  assign bus.out_bit   = (state_q == SEND) & cur_bit;
  assign busy          = (state_q == SEND);
  assign done          = (state_q == DONE);
  assign ones_cnt      = ones_q;

endmodule

// File: tb/tb_lut_readback.sv
// Directed bench for lut_readback: each scenario task checks its own results.
module tb_lut_readback;
  logic        clk;
  logic        rst;
  logic [15:0] ram;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  ones_cnt;

  int n_checks;
  int n_fail;

  lut_readback_if #(.AW(4)) bus ();

  lut_readback #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ram      (ram),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ram = '0; bus.out_ready = 1'b0;
    #3;
    n_checks++;
    if ({bus.out_valid, busy, done, ones_cnt, bus.out_addr, bus.out_bit} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b ones=%0d addr=%0d bit=%b, want all 0",
               bus.out_valid, busy, done, ones_cnt, bus.out_addr, bus.out_bit);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] tbl;
    tbl = 16'hFF4C;
    ram = tbl; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_addr !== 4'(k) || bus.out_bit !== tbl[k]) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b busy=%b addr=%0d bit=%b, want 1 1 %0d %b",
                 k, bus.out_valid, busy, bus.out_addr, bus.out_bit, k, tbl[k]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || ones_cnt !== 5'd11) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b busy=%b v=%b ones=%0d, want 1 0 0 11",
               done, busy, bus.out_valid, ones_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || ones_cnt !== 5'd11) begin
      n_fail++;
      $display("FAIL basic_after: got done=%b ones=%0d, want 0 11", done, ones_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] tbl;
    logic [3:0]  p_addr;
    logic        p_bit, p_stall, seen_done;
    int          next_beat, done_cyc;
    tbl = 16'hAAAA;
    ram = tbl; start = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0;
    next_beat = 0; p_stall = 1'b0; p_addr = '0; p_bit = 1'b0; seen_done = 1'b0; done_cyc = 0;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      bus.out_ready = c[0];
      if (done === 1'b1) begin
        seen_done = 1'b1;
        done_cyc  = c;
      end else if (bus.out_valid === 1'b1) begin
        if (p_stall) begin
          n_checks++;
          if (bus.out_addr !== p_addr || bus.out_bit !== p_bit) begin
            n_fail++;
            $display("FAIL bp_stable_c%0d: got addr=%0d bit=%b, want %0d %b",
                     c, bus.out_addr, bus.out_bit, p_addr, p_bit);
          end
        end
        if (bus.out_ready) begin
          n_checks++;
          if (bus.out_addr !== 4'(next_beat) || bus.out_bit !== tbl[next_beat]) begin
            n_fail++;
            $display("FAIL bp_beat%0d: got addr=%0d bit=%b, want %0d %b",
                     next_beat, bus.out_addr, bus.out_bit, next_beat, tbl[next_beat]);
          end
          next_beat++;
        end
        p_stall = !bus.out_ready;
        p_addr  = bus.out_addr;
        p_bit   = bus.out_bit;
      end
      if (!seen_done) tick();
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (!seen_done || done_cyc != 32 || next_beat != 16 || ones_cnt !== 5'd8) begin
      n_fail++;
      $display("FAIL bp_done: got seen=%b cycle=%0d beats=%0d ones=%0d, want 1 32 16 8",
               seen_done, done_cyc, next_beat, ones_cnt);
    end
    tick();
  endtask

  task automatic test_snapshot();
    ram = 16'h0001; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) ram = 16'hFFFF;
      n_checks++;
      if (bus.out_addr !== 4'(k) || bus.out_bit !== (k == 0)) begin
        n_fail++;
        $display("FAIL snap_beat%0d: got addr=%0d bit=%b, want %0d %b",
                 k, bus.out_addr, bus.out_bit, k, (k == 0));
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || ones_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL snap_done: got done=%b ones=%0d, want 1 1", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_abort();
    ram = 16'hFFFF; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (bus.out_addr !== 4'd5 || bus.out_valid !== 1'b1 || ones_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL abort_pre: got addr=%0d v=%b ones=%0d, want 5 1 5",
               bus.out_addr, bus.out_valid, ones_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0 || ones_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b v=%b done=%b ones=%0d, want 0 0 0 5",
               busy, bus.out_valid, done, ones_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ones_cnt !== 5'd5) begin
        n_fail++;
        $display("FAIL abort_hold%0d: got done=%b busy=%b ones=%0d, want 0 0 5",
                 k, done, busy, ones_cnt);
      end
    end
  endtask

  task automatic test_start_ignored();
    ram = 16'h00F0; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || bus.out_addr !== 4'(k)) begin
        n_fail++;
        $display("FAIL ign_beat%0d: got done=%b busy=%b addr=%0d, want 0 1 %0d",
                 k, done, busy, bus.out_addr, k);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || ones_cnt !== 5'd4) begin
      n_fail++;
      $display("FAIL ign_done: got done=%b ones=%0d, want 1 4", done, ones_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
    ram = 16'h0003;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.out_addr !== 4'd0 || ones_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL ign_restart: got busy=%b addr=%0d ones=%0d, want 1 0 0",
               busy, bus.out_addr, ones_cnt);
    end
    for (int k = 0; k < 16; k++) tick();
    n_checks++;
    if (done !== 1'b1 || ones_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL ign_done2: got done=%b ones=%0d, want 1 2", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    ram = 16'hFFFF; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, busy, done, ones_cnt, bus.out_addr, bus.out_bit} !== 13'd0) begin
      n_fail++;
      $display("FAIL arst_outputs: got v=%b b=%b d=%b ones=%0d addr=%0d bit=%b, want all 0",
               bus.out_valid, busy, done, ones_cnt, bus.out_addr, bus.out_bit);
    end
    #2;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_after%0d: got done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
